// File: rtl/sync_arb_client.sv
// Clocked front end for an M-to-1 asynchronous tree arbiter: turns level requests into
// 4-phase req/gnt handshakes and returns synchronised, registered grants to the clients.
module sync_arb_client #(
  parameter int MR       = 2,
  parameter int SYNC     = 2,
  parameter int HOLD_MAX = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [MR-1:0] usr_req,
  input  logic [MR-1:0] usr_done,
  output logic [MR-1:0] usr_gnt,
  output logic [MR-1:0] usr_abort,
  output logic [MR-1:0] arb_req,
  input  logic [MR-1:0] arb_gnt,
  output logic [MR-1:0] busy,
  output logic          err_mutex
);

  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_REQ     = 2'd1;
  localparam logic [1:0]  S_GRANT   = 2'd2;
  localparam logic [1:0]  S_REL     = 2'd3;
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_MAX - 1);
  localparam bit          HOLD_EN   = (HOLD_MAX != 0);

  logic [MR-1:0] sync_q [SYNC];
  logic [MR-1:0] sync_d [SYNC];
  logic [MR-1:0] gs;

  logic [1:0]    state_q [MR];
  logic [1:0]    state_d [MR];
  logic [15:0]   hold_q  [MR];
  logic [15:0]   hold_d  [MR];

  logic [MR-1:0] arb_req_q,   arb_req_d;
  logic [MR-1:0] usr_gnt_q,   usr_gnt_d;
  logic [MR-1:0] usr_abort_q, usr_abort_d;
  logic [MR-1:0] busy_q,      busy_d;
  logic          err_mutex_q, err_mutex_d;
  logic          multi_gnt;

  assign gs = sync_q[SYNC-1];

  always_comb begin
    sync_d[0] = arb_gnt;
    for (int k = 1; k < SYNC; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // Clearing the lowest set bit leaves something only when two or more grants are high.
  if (MR > 1) begin : g_mutex
    assign multi_gnt = |(gs & (gs - MR'(1)));
  end else begin : g_single
    assign multi_gnt = 1'b0;
  end

  always_comb begin
    err_mutex_d = err_mutex_q | multi_gnt;
    for (int i = 0; i < MR; i++) begin
      state_d[i]     = state_q[i];
      usr_abort_d[i] = 1'b0;
      case (state_q[i])
        S_IDLE: begin
          if (usr_req[i] && !gs[i]) state_d[i] = S_REQ;
        end
        S_REQ: begin
          if (gs[i]) state_d[i] = usr_req[i] ? S_GRANT : S_REL;
        end
        S_GRANT: begin
          if (usr_done[i]) begin
            state_d[i] = S_REL;
          end else if (HOLD_EN && (hold_q[i] == HOLD_LAST)) begin
            state_d[i]     = S_REL;
            usr_abort_d[i] = 1'b1;
          end
        end
        default: begin
          if (!gs[i]) state_d[i] = S_IDLE;
        end
      endcase
      // Counter reads 0 during the first GRANT cycle, so HOLD_LAST marks the last one.
      hold_d[i]    = ((state_q[i] == S_GRANT) && (state_d[i] == S_GRANT)) ?
                     hold_q[i] + 16'd1 : 16'd0;
      arb_req_d[i] = (state_d[i] == S_REQ) || (state_d[i] == S_GRANT);
      usr_gnt_d[i] = (state_d[i] == S_GRANT);
      busy_d[i]    = (state_d[i] != S_IDLE);
    end
  end

  // Outputs get their own flops so arb_req never glitches while the state changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC; k++) sync_q[k] <= '0;
      for (int i = 0; i < MR; i++) begin
        state_q[i] <= S_IDLE;
        hold_q[i]  <= 16'd0;
      end
      arb_req_q   <= '0;
      usr_gnt_q   <= '0;
      usr_abort_q <= '0;
      busy_q      <= '0;
      err_mutex_q <= 1'b0;
    end else begin
      for (int k = 0; k < SYNC; k++) sync_q[k] <= sync_d[k];
      for (int i = 0; i < MR; i++) begin
        state_q[i] <= state_d[i];
        hold_q[i]  <= hold_d[i];
      end
      arb_req_q   <= arb_req_d;
      usr_gnt_q   <= usr_gnt_d;
      usr_abort_q <= usr_abort_d;
      busy_q      <= busy_d;
      err_mutex_q <= err_mutex_d;
    end
  end

  assign arb_req   = arb_req_q;
  assign usr_gnt   = usr_gnt_q;
  assign usr_abort = usr_abort_q;
  assign busy      = busy_q;
  assign err_mutex = err_mutex_q;

endmodule

// File: tb/tb_sync_arb_client.sv
// Bench for sync_arb_client: behavioural arbiter, phase-level reference model checked
// every cycle, and directed scenarios with hand-computed expectations.
module tb_sync_arb_client;

  localparam int MR_T   = 4;
  localparam int SYNC_T = 2;
  localparam int HOLD_T = 8;

  logic            clk;
  logic            rst;
  logic [MR_T-1:0] usr_req;
  logic [MR_T-1:0] usr_done;
  logic [MR_T-1:0] usr_gnt;
  logic [MR_T-1:0] usr_abort;
  logic [MR_T-1:0] arb_req;
  logic [MR_T-1:0] arb_gnt;
  logic [MR_T-1:0] busy;
  logic            err_mutex;

  int checks = 0;
  int errors = 0;

  sync_arb_client #(.MR(MR_T), .SYNC(SYNC_T), .HOLD_MAX(HOLD_T)) dut (
    .clk       (clk),
    .rst       (rst),
    .usr_req   (usr_req),
    .usr_done  (usr_done),
    .usr_gnt   (usr_gnt),
    .usr_abort (usr_abort),
    .arb_req   (arb_req),
    .arb_gnt   (arb_gnt),
    .busy      (busy),
    .err_mutex (err_mutex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arbiter: 3 ns response, one grant at a time, lowest pending request wins.
  logic [MR_T-1:0] arb_mdl;
  logic [MR_T-1:0] arb_ovr_val;
  logic            arb_ovr;
  assign arb_gnt = arb_ovr ? arb_ovr_val : arb_mdl;

  initial begin
    arb_mdl = '0;
    forever begin
      #1;
      if (arb_mdl != 0 && (arb_mdl & arb_req) == 0) begin
        #3;
        if ($time % 10 == 5) #1;
        arb_mdl = '0;
      end else if (arb_mdl == 0 && arb_req != 0) begin
        #3;
        if ($time % 10 == 5) #1;
        arb_mdl = arb_req & (~arb_req + 4'd1);
      end
    end
  end

  // Reference model: each channel's phase follows the handshake rules directly.
  typedef enum {M_IDLE, M_REQ, M_GRANT, M_REL} phase_t;
  phase_t          m_ph   [MR_T];
  int              m_held [MR_T];
  logic [MR_T-1:0] m_abort;
  logic            m_err;
  logic [MR_T-1:0] m_hist [SYNC_T];
  logic [MR_T-1:0] m_gs;
  logic [MR_T-1:0] exp_req, exp_gnt, exp_busy;

  assign m_gs = m_hist[SYNC_T-1];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MR_T; i++) begin
        m_ph[i]   <= M_IDLE;
        m_held[i] <= 0;
      end
      for (int k = 0; k < SYNC_T; k++) m_hist[k] <= '0;
      m_abort <= '0;
      m_err   <= 1'b0;
    end else begin
      m_hist[0] <= arb_gnt;
      for (int k = 1; k < SYNC_T; k++) m_hist[k] <= m_hist[k-1];
      if ($countones(m_gs) > 1) m_err <= 1'b1;
      m_abort <= '0;
      for (int i = 0; i < MR_T; i++) begin
        case (m_ph[i])
          M_IDLE:  if (usr_req[i] && !m_gs[i]) m_ph[i] <= M_REQ;
          M_REQ: begin
            m_held[i] <= 0;
            if (m_gs[i]) begin
              if (usr_req[i]) m_ph[i] <= M_GRANT;
              else            m_ph[i] <= M_REL;
            end
          end
          M_GRANT: begin
            m_held[i] <= m_held[i] + 1;
            if (usr_done[i]) begin
              m_ph[i] <= M_REL;
            end else if (HOLD_T != 0 && m_held[i] + 1 == HOLD_T) begin
              m_ph[i]    <= M_REL;
              m_abort[i] <= 1'b1;
            end
          end
          default: if (!m_gs[i]) m_ph[i] <= M_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    exp_req  = '0;
    exp_gnt  = '0;
    exp_busy = '0;
    for (int i = 0; i < MR_T; i++) begin
      exp_req[i]  = (m_ph[i] == M_REQ) || (m_ph[i] == M_GRANT);
      exp_gnt[i]  = (m_ph[i] == M_GRANT);
      exp_busy[i] = (m_ph[i] != M_IDLE);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_arb_req",   32'(arb_req),   32'(exp_req));
      chk("model_usr_gnt",   32'(usr_gnt),   32'(exp_gnt));
      chk("model_busy",      32'(busy),      32'(exp_busy));
      chk("model_usr_abort", 32'(usr_abort), 32'(m_abort));
      chk("model_err_mutex", 32'(err_mutex), 32'(m_err));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_gnt(input string nm, input logic [MR_T-1:0] want, input int lim);
    int n;
    n = 0;
    while (usr_gnt !== want && n < lim) begin
      cyc();
      n++;
    end
    chk(nm, 32'(usr_gnt), 32'(want));
  endtask

  task automatic wait_idle(input string nm, input int lim);
    int n;
    n = 0;
    while (busy !== '0 && n < lim) begin
      cyc();
      n++;
    end
    chk(nm, 32'(busy), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    rst         = 1'b0;
    usr_req     = '0;
    usr_done    = '0;
    arb_ovr     = 1'b0;
    arb_ovr_val = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_arb_req",   32'(arb_req),   32'h0);
    chk("rst_usr_gnt",   32'(usr_gnt),   32'h0);
    chk("rst_busy",      32'(busy),      32'h0);
    chk("rst_usr_abort", 32'(usr_abort), 32'h0);
    chk("rst_err_mutex", 32'(err_mutex), 32'h0);
    repeat (3) cyc();
    rst = 1'b0;
    cyc();

    // Single request on channel 2
    usr_req = 4'b0100;
    cyc();
    chk("single_req_1edge", 32'(arb_req), 32'h4);
    cyc(); chk("single_gnt_e1", 32'(usr_gnt), 32'h0);
    cyc(); chk("single_gnt_e2", 32'(usr_gnt), 32'h0);
    cyc(); chk("single_gnt_e3", 32'(usr_gnt), 32'h4);
    usr_done = 4'b0100;
    usr_req  = 4'b0000;
    cyc();
    usr_done = '0;
    chk("single_req_fall", 32'(arb_req), 32'h0);
    chk("single_gnt_fall", 32'(usr_gnt), 32'h0);
    chk("single_busy_rel", 32'(busy),    32'h4);
    cyc(); cyc();
    chk("single_busy_e2",  32'(busy),    32'h4);
    cyc();
    chk("single_busy_e3",  32'(busy),    32'h0);

    // usr_done while idle is ignored
    usr_done = 4'b1111;
    cyc();
    usr_done = '0;
    chk("done_idle_busy", 32'(busy), 32'h0);

    // Contention between channels 0 and 3
    usr_req = 4'b1001;
    wait_gnt("cont_first", 4'b0001, 10);
    chk("cont_other_waits", 32'(arb_req), 32'h9);
    usr_done = 4'b0001;
    usr_req  = 4'b1000;
    cyc();
    usr_done = '0;
    wait_gnt("cont_second", 4'b1000, 12);
    chk("cont_no_mutex", 32'(err_mutex), 32'h0);
    usr_done = 4'b1000;
    usr_req  = '0;
    cyc();
    usr_done = '0;
    wait_idle("cont_idle", 12);

    // Withdrawal on channel 1
    usr_req = 4'b0010;
    cyc();
    chk("wd_req_up", 32'(arb_req), 32'h2);
    usr_req = '0;
    cyc(); chk("wd_req_hold1", 32'(arb_req), 32'h2);
    cyc(); chk("wd_req_hold2", 32'(arb_req), 32'h2);
    cyc();
    chk("wd_req_fall", 32'(arb_req), 32'h0);
    chk("wd_busy_rel", 32'(busy),    32'h2);
    wait_idle("wd_idle", 12);

    // Hold limit on channel 0
    usr_req = 4'b0001;
    wait_gnt("hold_gnt", 4'b0001, 10);
    n = 0;
    while (usr_gnt[0] && n < 20) begin
      n++;
      cyc();
    end
    chk("hold_cycles", 32'(n), 32'd8);
    chk("hold_abort",  32'(usr_abort), 32'h1);
    usr_req = '0;
    cyc();
    chk("hold_abort_1cyc", 32'(usr_abort), 32'h0);
    wait_idle("hold_idle", 12);

    // usr_done in the same cycle as the timeout
    usr_req = 4'b0001;
    wait_gnt("coll_gnt", 4'b0001, 10);
    repeat (7) cyc();
    chk("coll_still_gnt", 32'(usr_gnt), 32'h1);
    usr_done = 4'b0001;
    usr_req  = '0;
    cyc();
    usr_done = '0;
    chk("coll_gnt_fall", 32'(usr_gnt),   32'h0);
    chk("coll_no_abort", 32'(usr_abort), 32'h0);
    wait_idle("coll_idle", 12);

    // Mutual-exclusion checker
    arb_ovr_val = 4'b0011;
    arb_ovr     = 1'b1;
    cyc(); chk("mutex_e1", 32'(err_mutex), 32'h0);
    cyc(); chk("mutex_e2", 32'(err_mutex), 32'h0);
    cyc(); chk("mutex_e3", 32'(err_mutex), 32'h1);
    arb_ovr = 1'b0;
    repeat (4) cyc();
    chk("mutex_sticky", 32'(err_mutex), 32'h1);
    chk("mutex_no_fsm", 32'(busy),      32'h0);

    // Reset while channel 1 holds the grant, then a stale grant
    usr_req = 4'b0010;
    wait_gnt("rstg_gnt", 4'b0010, 10);
    arb_ovr_val = 4'b0010;
    arb_ovr     = 1'b1;
    #1;
    rst     = 1'b1;
    usr_req = '0;
    #1;
    chk("rstg_arb_req", 32'(arb_req),   32'h0);
    chk("rstg_usr_gnt", 32'(usr_gnt),   32'h0);
    chk("rstg_busy",    32'(busy),      32'h0);
    chk("rstg_err",     32'(err_mutex), 32'h0);
    cyc();
    rst = 1'b0;
    cyc(); cyc();
    usr_req = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("stale_req_low", 32'(arb_req), 32'h0);
      chk("stale_idle",    32'(busy),    32'h0);
    end
    arb_ovr = 1'b0;
    cyc(); chk("stale_drop_e1", 32'(arb_req), 32'h0);
    cyc(); chk("stale_drop_e2", 32'(arb_req), 32'h0);
    cyc(); chk("stale_rereq",   32'(arb_req), 32'h2);
    wait_gnt("stale_gnt", 4'b0010, 10);
    usr_done = 4'b0010;
    usr_req  = '0;
    cyc();
    usr_done = '0;
    wait_idle("final_idle", 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
